if_id_front: RTL

- Fetch-side front end of the 5-stage pipeline: PC register, next-PC select, and the IF/ID pipeline register.
- Consumes the stall controls produced by the hazard detection unit (PC write enable, IF/ID write enable) and the branch/jump redirect from ID.
- Performs the instruction-memory fetch handshake.
- Turns those requests into held, advanced, or bubbled pipeline state each cycle.

---
 rtl/if_id_front_pkg.sv | 43 ++++
 rtl/if_id_front_if.sv | 42 ++++
 rtl/if_id_front_if_id_reg.sv | 45 ++++
 rtl/if_id_front.sv | 105 ++++++++++
 4 files changed

// File: rtl/if_id_front_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpu_pkg
// Brief    : Shared pipeline types, reset defaults and fetch-action decode.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    typedef logic [31:0] word_t;

    localparam word_t C_RESET_PC  = 32'h0000_0000;
    localparam word_t C_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        MISS  = 1'b1
    } fetch_state_t;

    // Per-cycle pipeline action; the ID/EX control mux uses the same encoding.
    typedef enum logic [1:0] {
        FA_STALL    = 2'd0,
        FA_REDIRECT = 2'd1,
        FA_MISS     = 2'd2,
        FA_ADVANCE  = 2'd3
    } fetch_act_t;

    // pc_write=1 with if_id_write=0 on an advancing cycle has no meaning, so it
    // is folded into the stall case.
    function automatic fetch_act_t fetch_decide(
        input logic pc_write,
        input logic if_id_write,
        input logic redirect,
        input logic instr_valid
    );
        if (!pc_write)         return FA_STALL;
        else if (redirect)     return FA_REDIRECT;
        else if (!instr_valid) return FA_MISS;
        else if (!if_id_write) return FA_STALL;
        else                   return FA_ADVANCE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_front_if.sv
`default_nettype none
// ============================================================================
// Interface : if_id_front_if
// Brief     : Hazard controls, redirect, imem handshake and IF/ID outputs.
// Revision  : 1.0
// ============================================================================
interface if_id_front_if
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             pc_write_i;
    logic             if_id_write_i;
    logic             flush_i;
    word_t            branch_target_i;
    logic             jump_i;
    word_t            jump_target_i;
    word_t            instr_i;
    logic             instr_valid_i;
    word_t            pc_o;
    word_t            if_id_pc4_o;
    word_t            if_id_instr_o;
    logic             if_id_valid_o;
    logic             miss_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] miss_cnt_o;

    modport master (
        output pc_write_i, if_id_write_i, flush_i, branch_target_i,
               jump_i, jump_target_i, instr_i, instr_valid_i,
        input  pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o,
               miss_o, stall_cnt_o, miss_cnt_o
    );

    modport slave (
        input  pc_write_i, if_id_write_i, flush_i, branch_target_i,
               jump_i, jump_target_i, instr_i, instr_valid_i,
        output pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o,
               miss_o, stall_cnt_o, miss_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/if_id_front_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : Pipeline register (PC+4, instruction, valid) with write enable
//            and synchronous bubble load.
// Revision : 1.0
// ============================================================================
module if_id_reg
    import cpu_pkg::*;
#(
    parameter word_t NOP_INSTR = C_NOP_INSTR
)(
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  i_we,
    input  wire logic  i_bubble,
    input  wire word_t i_pc4,
    input  wire word_t i_instr,
    input  wire logic  i_valid,
    output word_t      o_pc4,
    output word_t      o_instr,
    output logic       o_valid
);
    word_t r_pc4;
    word_t r_instr;
    logic  r_valid;

    // Bubble takes precedence over a plain write.
    always_ff @(posedge clk) begin
        if (rst || i_bubble) begin
            r_pc4   <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_we) begin
            r_pc4   <= i_pc4;
            r_instr <= i_instr;
            r_valid <= i_valid;
        end
    end

    assign o_pc4   = r_pc4;
    assign o_instr = r_instr;
    assign o_valid = r_valid;
endmodule
`default_nettype wire

// File: rtl/if_id_front.sv
`default_nettype none
// ============================================================================
// Module   : if_id_front
// Brief    : Fetch front end: PC register, next-PC select, imem handshake and
//            IF/ID register, with hazard-stall and imem-miss counters.
// Revision : 1.0
// ============================================================================
module if_id_front
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC  = C_RESET_PC,
    parameter word_t NOP_INSTR = C_NOP_INSTR,
    parameter int    CNT_W     = 16
)(
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    if_id_front_if.slave  bus
);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    word_t            r_pc;
    fetch_state_t     r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    fetch_act_t   w_act;
    word_t        w_pc_next;
    word_t        w_pc4;
    fetch_state_t w_state_next;
    logic         w_ifid_we;
    logic         w_ifid_bubble;
    logic         w_redirect;
    logic         w_illegal;

    assign w_redirect = bus.flush_i | bus.jump_i;
    assign w_pc4      = r_pc + 32'd4;
    assign w_illegal  = bus.pc_write_i & ~bus.if_id_write_i & ~w_redirect & bus.instr_valid_i;

    always_comb begin
        w_act         = fetch_decide(bus.pc_write_i, bus.if_id_write_i,
                                     w_redirect, bus.instr_valid_i);
        w_pc_next     = r_pc;
        w_state_next  = r_state;
        w_ifid_we     = 1'b0;
        w_ifid_bubble = 1'b0;
        unique case (w_act)
            FA_STALL: begin
                w_ifid_bubble = bus.if_id_write_i;
            end
            FA_REDIRECT: begin
                w_pc_next     = bus.flush_i ? bus.branch_target_i : bus.jump_target_i;
                w_ifid_bubble = 1'b1;
                w_state_next  = FETCH;
            end
            FA_MISS: begin
                w_ifid_bubble = bus.if_id_write_i;
                w_state_next  = MISS;
            end
            FA_ADVANCE: begin
                w_pc_next     = w_pc4;
                w_ifid_we     = 1'b1;
                w_state_next  = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc        <= RESET_PC;
            r_state     <= FETCH;
            r_stall_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_state <= w_state_next;
            if (w_act == FA_STALL && r_stall_cnt != C_CNT_MAX)
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            if (w_act == FA_MISS && r_miss_cnt != C_CNT_MAX)
                r_miss_cnt <= r_miss_cnt + C_CNT_ONE;
            a_hazard_ctl_legal: assert (!w_illegal);
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_we     (w_ifid_we),
        .i_bubble (w_ifid_bubble),
        .i_pc4    (w_pc4),
        .i_instr  (bus.instr_i),
        .i_valid  (1'b1),
        .o_pc4    (bus.if_id_pc4_o),
        .o_instr  (bus.if_id_instr_o),
        .o_valid  (bus.if_id_valid_o)
    );

    assign bus.pc_o        = r_pc;
    assign bus.miss_o      = (r_state == MISS);
    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.miss_cnt_o  = r_miss_cnt;
endmodule
`default_nettype wire
